// File: rtl/move_sprite_bounce.sv
// Moves a sprite's top-left corner once per accepted frame tick. Each axis either bounces off
// or wraps around the visible area, and edge and corner hits are reported as one-cycle pulses.
module move_sprite_bounce #(
  parameter int unsigned POS_W    = 12,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned PIC_W    = 64,
  parameter int unsigned PIC_H    = 48,
  parameter int unsigned INIT_X   = 288,
  parameter int unsigned INIT_Y   = 216
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  input  logic             loc_rst,
  input  logic             VS_negedge,
  input  logic             move_en,
  input  logic             mode,
  input  logic [3:0]       step_x,
  input  logic [3:0]       step_y,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             dir_x,
  output logic             dir_y,
  output logic             edge_hit,
  output logic             corner_hit,
  output logic [15:0]      tick_cnt
);

  localparam logic [POS_W:0]   MAX_X  = (POS_W+1)'(H_ACTIVE - PIC_W);
  localparam logic [POS_W:0]   MAX_Y  = (POS_W+1)'(V_ACTIVE - PIC_H);
  localparam logic [POS_W-1:0] INIT_H = POS_W'(INIT_X);
  localparam logic [POS_W-1:0] INIT_V = POS_W'(INIT_Y);

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             hit;
  } axis_t;

  // One axis update. The arithmetic is one bit wider than the position so that
  // pos+step and pos+MAX+1 cannot overflow.
  function automatic axis_t axis_next(input logic [POS_W-1:0] pos, input logic dir,
                                      input logic [3:0] step, input logic wrap,
                                      input logic [POS_W:0] max);
    logic [POS_W:0] p, s, n, one;
    axis_t r;
    p   = {1'b0, pos};
    s   = {{(POS_W-3){1'b0}}, step};
    n   = p + s;
    one = (POS_W+1)'(1);
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    // A zero step freezes the axis, even when it sits on a boundary.
    if (step != 4'd0) begin
      if (!wrap) begin
        if (dir) begin
          if (n >= max) begin
            r.pos = max[POS_W-1:0];
            r.dir = 1'b0;
            r.hit = 1'b1;
          end else begin
            r.pos = POS_W'(n);
          end
        end else begin
          if (p <= s) begin
            r.pos = '0;
            r.dir = 1'b1;
            r.hit = 1'b1;
          end else begin
            r.pos = POS_W'(p - s);
          end
        end
      end else begin
        if (dir) begin
          if (n > max) begin
            r.pos = POS_W'(n - (max + one));
            r.hit = 1'b1;
          end else begin
            r.pos = POS_W'(n);
          end
        end else begin
          if (p < s) begin
            r.pos = POS_W'(p + max + one - s);
            r.hit = 1'b1;
          end else begin
            r.pos = POS_W'(p - s);
          end
        end
      end
    end
    return r;
  endfunction

  logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             edge_q, edge_d, corner_q, corner_d;
  logic [15:0]      cnt_q, cnt_d;
  axis_t            ax, ay;

  assign ax = axis_next(hpos_q, dir_x_q, step_x, mode, MAX_X);
  assign ay = axis_next(vpos_q, dir_y_q, step_y, mode, MAX_Y);

  always_comb begin
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    cnt_d    = cnt_q;
    edge_d   = 1'b0;
    corner_d = 1'b0;
    if (loc_rst) begin
      hpos_d  = INIT_H;
      vpos_d  = INIT_V;
      dir_x_d = 1'b1;
      dir_y_d = 1'b1;
      cnt_d   = '0;
    end else if (VS_negedge && move_en) begin
      hpos_d   = ax.pos;
      vpos_d   = ay.pos;
      dir_x_d  = ax.dir;
      dir_y_d  = ay.dir;
      edge_d   = ax.hit | ay.hit;
      corner_d = ax.hit & ay.hit;
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q   <= INIT_H;
      vpos_q   <= INIT_V;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      edge_q   <= 1'b0;
      corner_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      edge_q   <= edge_d;
      corner_q <= corner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign edge_hit   = edge_q;
  assign corner_hit = corner_q;
  assign tick_cnt   = cnt_q;

endmodule

// File: tb/tb_move_sprite_bounce.sv
// Self-checking bench for move_sprite_bounce: an integer reference model is compared every
// cycle, and literal expectations pin the model at known points.
module tb_move_sprite_bounce;

  localparam int POS_W = 12;
  localparam int MAX_X = 576;
  localparam int MAX_Y = 432;
  localparam int INIT_X = 288;
  localparam int INIT_Y = 216;

  logic             clk_25MHz = 1'b0;
  logic             rst_n = 1'b1;
  logic             loc_rst = 1'b0;
  logic             VS_negedge = 1'b0;
  logic             move_en = 1'b0;
  logic             mode = 1'b0;
  logic [3:0]       step_x = 4'd0;
  logic [3:0]       step_y = 4'd0;
  logic [POS_W-1:0] hpos, vpos;
  logic             dir_x, dir_y, edge_hit, corner_hit;
  logic [15:0]      tick_cnt;

  int n_vec = 0;
  int n_err = 0;

  int m_h = INIT_X, m_v = INIT_Y, m_dx = 1, m_dy = 1, m_eh = 0, m_ch = 0, m_cnt = 0;

  move_sprite_bounce dut (
    .clk_25MHz  (clk_25MHz),
    .rst_n      (rst_n),
    .loc_rst    (loc_rst),
    .VS_negedge (VS_negedge),
    .move_en    (move_en),
    .mode       (mode),
    .step_x     (step_x),
    .step_y     (step_y),
    .hpos       (hpos),
    .vpos       (vpos),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .edge_hit   (edge_hit),
    .corner_hit (corner_hit),
    .tick_cnt   (tick_cnt)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = INIT_X; m_v = INIT_Y; m_dx = 1; m_dy = 1; m_eh = 0; m_ch = 0; m_cnt = 0;
  endtask

  // Bounce clamps to the boundary and reverses; wrap is modular over MAX+1 positions.
  task automatic axis(inout int pos, inout int dir, output int hit,
                      input int step, input int wrap, input int max);
    int t;
    hit = 0;
    if (step != 0) begin
      t = dir != 0 ? pos + step : pos - step;
      if (wrap != 0) begin
        hit = (t > max || t < 0) ? 1 : 0;
        pos = (t + max + 1) % (max + 1);
      end else if (dir != 0 && t >= max) begin
        pos = max; dir = 0; hit = 1;
      end else if (dir == 0 && t <= 0) begin
        pos = 0; dir = 1; hit = 1;
      end else begin
        pos = t;
      end
    end
  endtask

  task automatic model_step();
    int hx, hy;
    if (rst_n) begin
      m_eh = 0;
      m_ch = 0;
      if (loc_rst) begin
        model_reset();
      end else if (VS_negedge && move_en) begin
        axis(m_h, m_dx, hx, int'(step_x), int'(mode), MAX_X);
        axis(m_v, m_dy, hy, int'(step_y), int'(mode), MAX_Y);
        m_eh = hx | hy;
        m_ch = hx & hy;
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
  endtask

  task automatic cyc(input bit vs, input bit lr);
    VS_negedge = vs;
    loc_rst = lr;
    @(posedge clk_25MHz);
    model_step();
    #1;
    VS_negedge = 1'b0;
    loc_rst = 1'b0;
  endtask

  always @(negedge clk_25MHz) begin
    if (rst_n) begin
      check("hpos", int'(hpos), m_h);
      check("vpos", int'(vpos), m_v);
      check("dir_x", int'(dir_x), m_dx);
      check("dir_y", int'(dir_y), m_dy);
      check("edge_hit", int'(edge_hit), m_eh);
      check("corner_hit", int'(corner_hit), m_ch);
      check("tick_cnt", int'(tick_cnt), m_cnt);
    end
  end

  initial begin
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst hpos", int'(hpos), 288);
    check("rst vpos", int'(vpos), 216);
    check("rst dirs", int'({dir_x, dir_y}), 3);
    check("rst hits", int'({edge_hit, corner_hit}), 0);
    check("rst cnt", int'(tick_cnt), 0);
    #44 rst_n = 1'b1;

    // Bounce at the right edge.
    mode = 1'b0; step_x = 4'd15; step_y = 4'd0; move_en = 1'b1;
    repeat (19) cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("bounce t19 hpos", int'(hpos), 573);
    cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("bounce t20 hpos", int'(hpos), 576);
    check("bounce t20 dir_x", int'(dir_x), 0);
    check("bounce t20 edge", int'(edge_hit), 1);
    cyc(1'b0, 1'b0);
    @(negedge clk_25MHz);
    check("bounce pulse end", int'(edge_hit), 0);
    cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("bounce t21 hpos", int'(hpos), 561);
    check("bounce t21 vpos", int'(vpos), 216);

    // Wrap at the right edge.
    cyc(1'b0, 1'b1);
    mode = 1'b1;
    repeat (20) cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("wrap t20 hpos", int'(hpos), 11);
    check("wrap t20 dir_x", int'(dir_x), 1);
    check("wrap t20 edge", int'(edge_hit), 1);

    // Simultaneous corner bounce.
    cyc(1'b0, 1'b1);
    mode = 1'b0; step_x = 4'd8; step_y = 4'd6;
    repeat (36) cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("corner hpos", int'(hpos), 576);
    check("corner vpos", int'(vpos), 432);
    check("corner dirs", int'({dir_x, dir_y}), 0);
    check("corner edge", int'(edge_hit), 1);
    check("corner hit", int'(corner_hit), 1);
    check("corner cnt", int'(tick_cnt), 36);

    // Zero steps freeze both axes with no hit.
    step_x = 4'd0; step_y = 4'd0;
    cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("freeze hpos", int'(hpos), 576);
    check("freeze edge", int'(edge_hit), 0);
    check("freeze cnt", int'(tick_cnt), 37);

    // Wrap down to exactly 0, freeze there in bounce mode, then wrap under 0.
    mode = 1'b1; step_x = 4'd12;
    repeat (48) cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("wrap to 0 hpos", int'(hpos), 0);
    check("wrap to 0 edge", int'(edge_hit), 0);
    mode = 1'b0; step_x = 4'd0;
    cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("freeze at 0 edge", int'(edge_hit), 0);
    check("freeze at 0 dir_x", int'(dir_x), 0);
    mode = 1'b1; step_x = 4'd5;
    cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("wrap under hpos", int'(hpos), 572);
    check("wrap under edge", int'(edge_hit), 1);

    // Relocate wins over a coincident tick.
    cyc(1'b0, 1'b1);
    mode = 1'b0; step_x = 4'd8; step_y = 4'd6;
    repeat (5) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    @(negedge clk_25MHz);
    check("reloc hpos", int'(hpos), 288);
    check("reloc vpos", int'(vpos), 216);
    check("reloc cnt", int'(tick_cnt), 0);
    check("reloc edge", int'(edge_hit), 0);

    // move_en=0 ignores ticks.
    repeat (3) cyc(1'b1, 1'b0);
    move_en = 1'b0;
    repeat (5) cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("hold hpos", int'(hpos), 312);
    check("hold vpos", int'(vpos), 234);
    check("hold cnt", int'(tick_cnt), 3);
    move_en = 1'b1;

    // Asynchronous reset between clock edges.
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    check("async hpos", int'(hpos), 288);
    check("async vpos", int'(vpos), 216);
    check("async cnt", int'(tick_cnt), 0);
    #4 rst_n = 1'b1;

    // A tick under reset is discarded; the next tick moves from INIT.
    cyc(1'b1, 1'b0);
    VS_negedge = 1'b1;
    #5 rst_n = 1'b0;
    model_reset();
    @(posedge clk_25MHz);
    #1 VS_negedge = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk_25MHz);
    check("discard hpos", int'(hpos), 288);
    cyc(1'b1, 1'b0);
    @(negedge clk_25MHz);
    check("after rst hpos", int'(hpos), 296);
    check("after rst cnt", int'(tick_cnt), 1);

    // Mixed traffic checked against the model.
    for (int i = 0; i < 600; i++) begin
      if (i % 8 == 0) begin
        mode = 1'($urandom_range(0, 1));
        step_x = 4'($urandom_range(0, 15));
        step_y = 4'($urandom_range(0, 15));
      end
      move_en = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end
    @(negedge clk_25MHz);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/move_sprite_bounce.md
MOVE_SPRITE_BOUNCE -- requirements
Module: move_sprite_bounce

Interface
REQ-001 Parameter POS_W, default 12, width of position outputs and arithmetic base.
REQ-002 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter PIC_W, default 64, sprite width; SHALL be < H_ACTIVE.
REQ-005 Parameter PIC_H, default 48, sprite height; SHALL be < V_ACTIVE.
REQ-006 Parameter INIT_X, default 288, reset/relocate x; SHALL be <= H_ACTIVE-PIC_W.
REQ-007 Parameter INIT_Y, default 216, reset/relocate y; SHALL be <= V_ACTIVE-PIC_H.
REQ-008 clk_25MHz  in  1  sole clock; all registers on its rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 loc_rst  in  1  synchronous relocate-to-initial-position request, level-sensitive.
REQ-011 VS_negedge  in  1  one-cycle frame tick, high for one clk_25MHz cycle per frame.
REQ-012 move_en  in  1  1 = ticks move the sprite; 0 = ticks ignored.
REQ-013 mode  in  1  0 = bounce at edges; 1 = wrap around edges.
REQ-014 step_x  in  4  pixels moved in x per accepted tick.
REQ-015 step_y  in  4  pixels moved in y per accepted tick.
REQ-016 hpos  out  POS_W  sprite left x, range 0..MAX_X where MAX_X = H_ACTIVE-PIC_W.
REQ-017 vpos  out  POS_W  sprite top y, range 0..MAX_Y where MAX_Y = V_ACTIVE-PIC_H.
REQ-018 dir_x / dir_y  out  1 each  current direction, 1 = increasing.
REQ-019 edge_hit  out  1  one-cycle pulse when any axis bounced or wrapped on an accepted tick.
REQ-020 corner_hit  out  1  one-cycle pulse when both axes bounced or wrapped on the same tick.
REQ-021 tick_cnt  out  16  count of accepted ticks, wraps 65535 -> 0.

Function
REQ-022 An accepted tick is VS_negedge=1 and move_en=1 and loc_rst=0; all outputs update on that same clock edge (registered, 1-cycle latency from tick).
REQ-023 Priority per edge: loc_rst > accepted tick > hold.
REQ-024 loc_rst=1 SHALL load hpos=INIT_X, vpos=INIT_Y, dir_x=dir_y=1, tick_cnt=0, and clear edge_hit and corner_hit; holding it keeps these values.
REQ-025 Next-position arithmetic SHALL use POS_W+1 bits so no intermediate overflows.
REQ-026 Bounce, dir=1: n = pos+step; if n >= MAX then pos=MAX, dir=0, axis hit; else pos=n.
REQ-027 Bounce, dir=0: if pos <= step then pos=0, dir=1, axis hit; else pos=pos-step.
REQ-028 Wrap, dir=1: n = pos+step; if n > MAX then pos = n-(MAX+1), axis hit; else pos=n; dir unchanged.
REQ-029 Wrap, dir=0: if pos < step then pos = pos+(MAX+1)-step, axis hit; else pos=pos-step; dir unchanged.
REQ-030 step=0 SHALL freeze that axis with no hit, even at pos=0 or pos=MAX.
REQ-031 edge_hit = OR of axis hits and corner_hit = AND of axis hits, both high exactly one cycle after an accepted tick, else 0.
REQ-032 tick_cnt increments by 1 on every accepted tick.
REQ-033 Changes to mode, step_x and step_y take effect at the next accepted tick; position is never altered between ticks.
REQ-034 VS_negedge held high N cycles SHALL count as N ticks; the block performs no edge detection.

Reset
REQ-035 rst_n=0 SHALL immediately set hpos=INIT_X, vpos=INIT_Y, dir_x=dir_y=1, edge_hit=0, corner_hit=0 and tick_cnt=0, independent of the clock.
REQ-036 rst_n asserted mid-frame or mid-tick SHALL discard the pending update; the first accepted tick after release moves from INIT.

Verification
REQ-037 rst_n=0 -> hpos=288, vpos=216, dir_x=dir_y=1, edge_hit=0, tick_cnt=0.
REQ-038 mode=0, step_x=15, step_y=0, 20 ticks -> after tick 19 hpos=573; tick 20 gives hpos=576, dir_x=0, one edge_hit pulse; tick 21 gives hpos=561; vpos stays 216.
REQ-039 mode=1, step_x=15, 20 ticks -> tick 20 gives hpos=11 (588-577), dir_x stays 1, one edge_hit pulse.
REQ-040 mode=0, step_x=8, step_y=6, 36 ticks -> hpos=576, vpos=432, both directions 0, single-cycle edge_hit and corner_hit; tick_cnt=36.
REQ-041 After 5 ticks, loc_rst=1 in the same cycle as VS_negedge=1 -> hpos=288, vpos=216, tick_cnt=0, no hit pulse.
REQ-042 move_en=0 with 5 ticks -> outputs unchanged, tick_cnt unchanged; rst_n pulsed low between clock edges -> outputs reset immediately.
